// File: rtl/button_switch_input_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_switch_input_pkg
// Brief   : Register offsets and edge-mode encodings for button_switch_input.
// Revision: 1.0 - initial release
// ============================================================================
package button_switch_input_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

endpackage
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module  : input_debounce
// Brief   : One pin: 2-flop synchroniser, stability counter and debounced level.
// Revision: 1.0 - initial release
// ============================================================================
module input_debounce
    import button_switch_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic stable,
    output logic flip
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             differ;
    logic [CNT_W-1:0] count;

    assign differ = (sync != stable);
    // flip marks the edge on which stable takes the new level
    assign flip   = differ && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            count  <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
            if (flip) begin
                stable <= sync;
                count  <= '0;
            end else if (differ) begin
                count <= count + 1'b1;
            end else begin
                count <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_switch_input.sv
`default_nettype none
// ============================================================================
// Module  : button_switch_input
// Brief   : Debounced switch/key input peripheral with W1C edge capture and IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module button_switch_input
    import button_switch_input_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chipSelect,
    input  logic             write,
    input  logic             read,
    input  logic [1:0]       address,
    input  logic [31:0]      writeData,
    output logic [31:0]      readData,
    input  logic [WIDTH-1:0] in_pins,
    output logic             irq
);

    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] mask;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             rd_en;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            input_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .rst   (rst),
                .pin   (in_pins[i]),
                .sync  (sync[i]),
                .stable(stable[i]),
                .flip  (flip[i])
            );
        end
    endgenerate

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^writeData[31:WIDTH];
        end
    endgenerate

    assign wr_en = chipSelect && write;
    assign rd_en = chipSelect && read && !write;

    // stable still holds the old level when flip is high
    always_comb begin
        edge_set = '0;
        case (MODE)
            EDGE_RISE: edge_set = flip & ~stable;
            EDGE_FALL: edge_set = flip & stable;
            default:   edge_set = flip;
        endcase
    end

    assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? writeData[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
            default:   rd_mux[WIDTH-1:0] = sync;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cap <= '0;
            mask     <= '0;
            readData <= '0;
        end else begin
            // a new edge beats a simultaneous clear so no event is lost
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (wr_en && (address == ADDR_MASK)) begin
                mask <= writeData[WIDTH-1:0];
            end
            if (rd_en) begin
                readData <= rd_mux;
            end
        end
    end

    assign irq = |(edge_cap & mask);

endmodule
`default_nettype wire

// File: tb/tb_button_switch_input.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_switch_input
// Brief   : Scoreboarded bench for button_switch_input (WIDTH=10, 4-cycle debounce).
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_switch_input;
    import button_switch_input_pkg::*;

    localparam int WIDTH = 10;
    localparam int DB    = 4;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic             chipSelect = 1'b0;
    logic             write      = 1'b0;
    logic             read       = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic [31:0]      writeData  = 32'd0;
    logic [31:0]      readData;
    logic [WIDTH-1:0] in_pins    = '0;
    logic             irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] last_rd  = 32'd0;

    button_switch_input #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DB),
        .EDGE_MODE      (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .chipSelect(chipSelect),
        .write     (write),
        .read      (read),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .in_pins   (in_pins),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // one cycle = one active edge; inputs change and outputs are sampled at negedge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipSelect = 1'b1; write = 1'b1; address = a; writeData = d;
        tick(1);
        chipSelect = 1'b0; write = 1'b0; writeData = 32'd0;
    endtask

    task automatic pop_compare();
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, readData, e);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        last_rd = exp;
        chipSelect = 1'b1; read = 1'b1; address = a;
        tick(1);
        chipSelect = 1'b0; read = 1'b0;
        pop_compare();
    endtask

    // both strobes: the write happens and readData must keep its last value
    task automatic bus_write_read(input logic [1:0] a, input logic [31:0] d, input string tag);
        exp_q.push_back(last_rd);
        tag_q.push_back(tag);
        chipSelect = 1'b1; write = 1'b1; read = 1'b1; address = a; writeData = d;
        tick(1);
        chipSelect = 1'b0; write = 1'b0; read = 1'b0; writeData = 32'd0;
        pop_compare();
    endtask

    initial begin
        // reset with all pins high
        in_pins = '1;
        tick(3);
        check("rst_readData", readData, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;
        tick(4);
        bus_read(ADDR_DATA, 32'h000, "rst_data_early");
        tick(1);
        bus_read(ADDR_DATA, 32'h3FF, "rst_data");
        bus_read(ADDR_EDGE, 32'h3FF, "rst_edge");
        check("rst_irq_masked", {31'd0, irq}, 32'd0);

        // falling edges are not captured in rising mode
        bus_write(ADDR_EDGE, 32'h3FF);
        in_pins = '0;
        tick(8);
        bus_read(ADDR_EDGE, 32'h000, "no_fall_edge");
        bus_read(ADDR_DATA, 32'h000, "data_low");

        // latency: stable flips on the 6th edge after the pin change
        bus_write(ADDR_MASK, 32'h001);
        in_pins[0] = 1'b1;
        tick(5);
        check("lat_irq_e5", {31'd0, irq}, 32'd0);
        bus_read(ADDR_DATA, 32'h000, "lat_data_pre_e6");
        check("lat_irq_e6", {31'd0, irq}, 32'd1);
        bus_read(ADDR_DATA, 32'h001, "lat_data");
        bus_read(ADDR_EDGE, 32'h001, "lat_edge");
        bus_write(ADDR_EDGE, 32'h001);
        check("lat_irq_clr", {31'd0, irq}, 32'd0);

        // glitch rejection
        bus_write(ADDR_MASK, 32'h008);
        in_pins[3] = 1'b1;
        tick(3);
        in_pins[3] = 1'b0;
        tick(8);
        bus_read(ADDR_DATA, 32'h001, "glitch3_data");
        bus_read(ADDR_EDGE, 32'h000, "glitch3_edge");
        check("glitch3_irq", {31'd0, irq}, 32'd0);
        in_pins[3] = 1'b1;
        tick(4);
        in_pins[3] = 1'b0;
        tick(2);
        bus_read(ADDR_DATA, 32'h009, "glitch4_data");
        tick(8);
        bus_read(ADDR_EDGE, 32'h008, "glitch4_edge");
        check("glitch4_irq", {31'd0, irq}, 32'd1);
        bus_read(ADDR_DATA, 32'h001, "glitch4_release");
        bus_write(ADDR_EDGE, 32'h008);

        // W1C clear racing a new edge on the same bit
        bus_write(ADDR_MASK, 32'h004);
        in_pins[2] = 1'b1;
        tick(8);
        in_pins[2] = 1'b0;
        tick(8);
        bus_read(ADDR_EDGE, 32'h004, "race_pre");
        in_pins[2] = 1'b1;
        tick(5);
        bus_write(ADDR_EDGE, 32'h004);
        bus_read(ADDR_EDGE, 32'h004, "race_set_wins");
        check("race_irq", {31'd0, irq}, 32'd1);
        bus_write(ADDR_EDGE, 32'h000);
        bus_read(ADDR_EDGE, 32'h004, "w1c_zero_keeps");
        bus_write(ADDR_EDGE, 32'h004);
        check("race_irq_drop", {31'd0, irq}, 32'd0);
        bus_read(ADDR_EDGE, 32'h000, "race_cleared");

        // mask gating and RAW vs DATA
        in_pins[4] = 1'b1;
        tick(8);
        bus_write(ADDR_MASK, 32'h000);
        check("mask_zero_irq", {31'd0, irq}, 32'd0);
        bus_write(ADDR_MASK, 32'h010);
        check("mask_bit4_irq", {31'd0, irq}, 32'd1);
        bus_write(ADDR_MASK, 32'hFFFF_FFFF);
        bus_read(ADDR_MASK, 32'h3FF, "mask_upper_zero");
        bus_write(ADDR_MASK, 32'h010);
        in_pins[7] = 1'b1;
        tick(1);
        bus_read(ADDR_RAW, 32'h015, "raw_old");
        bus_read(ADDR_RAW, 32'h095, "raw_new");
        bus_read(ADDR_DATA, 32'h015, "data_old");

        // bus priority and read-only registers
        bus_write_read(ADDR_MASK, 32'h0AA, "wr_rd_hold");
        bus_read(ADDR_MASK, 32'h0AA, "wr_rd_written");
        tick(8);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_write(ADDR_RAW, 32'hFFFF_FFFF);
        bus_read(ADDR_DATA, 32'h095, "data_ro");
        bus_read(ADDR_RAW, 32'h095, "raw_ro");
        bus_read(ADDR_EDGE, 32'h090, "edge_after_ro");
        check("irq_mask_aa", {31'd0, irq}, 32'd1);

        // reset in the middle of a debounce
        in_pins[9] = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        check("mid_rst_rd", readData, 32'd0);
        rst = 1'b1;
        tick(4);
        bus_read(ADDR_DATA, 32'h000, "mid_rst_early");
        tick(1);
        bus_read(ADDR_DATA, 32'h295, "mid_rst_data");
        bus_read(ADDR_EDGE, 32'h295, "mid_rst_edge");
        bus_read(ADDR_MASK, 32'h000, "mid_rst_mask");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_switch_input.md
Name: button_switch_input

Overview:
- Memory-mapped input peripheral: the CPU reads board switches and pushbuttons through it, the read-side counterpart of the hex-display output register.
- Synchronises and debounces up to WIDTH asynchronous pins.
- Latches edges into a write-1-to-clear capture register and raises a maskable interrupt request.
- Sits on the same chipSelect/read/write data bus as the other multicycle-core peripherals.

Parameters:
- WIDTH, 10, number of input pins (switches and keys); 1..32.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required before a level is accepted (10 ms at 50 MHz); must be at least 2.
- EDGE_MODE, 0, edge type captured: 0 = rising, 1 = falling, 2 = both.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- chipSelect  in  1  peripheral selected this cycle
- write  in  1  write strobe; qualified by chipSelect
- read  in  1  read strobe; qualified by chipSelect
- address  in  2  register select (word offset)
- writeData  in  32  write data
- readData  out  32  registered read data
- in_pins  in  WIDTH  raw asynchronous pin inputs
- irq  out  1  interrupt request, level

Behaviour:
- Reset (rst low, asynchronous): sync flops, debounced level, counters, edge capture, mask and readData all go to 0. irq = 0.
- Synchroniser: two flops per bit, giving sync[i].
- Debounce (per bit, independent):
  - If sync != stable, the counter increments.
  - On the clock edge where the counter already equals DEBOUNCE_CYCLES-1 with the mismatch still present: stable <= sync and counter <= 0.
  - Any cycle with sync == stable clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - Total latency from a pin change to an update of stable: 2 + DEBOUNCE_CYCLES clocks.
- Edge capture: a bit of edge_cap is set on the same clock edge on which stable flips in the direction selected by EDGE_MODE. It stays set until cleared by software.
- Register map (address):
  - 0 DATA: RO, {0, stable}.
  - 1 EDGE: W1C; writing 1 to a bit clears it, writing 0 leaves it unchanged.
  - 2 MASK: RW, WIDTH bits; upper bits read as 0.
  - 3 RAW: RO, {0, sync}.
- Writes to addresses 0 and 3 are ignored.
- Write: takes effect on the clock edge where chipSelect && write.
- Read:
  - On the clock edge where chipSelect && read && !write, readData <= selected register (pre-edge value). It is valid from the next cycle, a 1-cycle latency.
  - readData holds its last value when not reading.
  - write has priority over read when both strobes are asserted.
- Simultaneous W1C clear and a new edge on the same bit in the same cycle: the set wins, so the bit stays 1 and no edge is lost.
- irq = |(edge_cap & mask), from registered state only. Glitch-free; no combinational path from bus inputs.
- Unused upper bits of writeData are ignored.
- Reset mid-debounce: the pending count is discarded and stable returns to 0. If a pin is held high through reset, it re-qualifies after 2 + DEBOUNCE_CYCLES clocks following reset release and produces a rising edge (EDGE_MODE 0 or 2).

Decomposition:
- Shared package: register offset constants ADDR_DATA=0, ADDR_EDGE=1, ADDR_MASK=2, ADDR_RAW=3, and EDGE_MODE encodings as a typedef enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
- One sub-module, input_debounce: one bit of synchroniser, counter and stable level, with output stable and a flip pulse.
- It is instantiated WIDTH times in a generate loop. The bus decode, edge/mask registers and irq logic stay in the top level.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4, WIDTH=10, EDGE_MODE=0):
- Reset: hold rst=0 with in_pins=10'h3FF -> readData=0, irq=0. Release rst -> reading DATA after 6+ clocks returns 0x3FF and EDGE returns 0x3FF.
- Latency: raise in_pins[0] just before edge 1 -> stable[0] rises at edge 6, not at edge 5; edge_cap[0]=1 at edge 6; with MASK=1, irq=1 after edge 6.
- Glitch: pulse in_pins[3] high for 3 clocks (synchronised) -> DATA bit 3 stays 0, EDGE stays 0, irq stays 0. Pulse for 4 clocks -> bit 3 is accepted.
- W1C race: edge_cap[2]=1; write EDGE=0x004 on the same edge as a new qualified edge on bit 2 -> EDGE still reads 0x004. Write 0x004 again with no edge -> reads 0x000 and irq drops the next cycle.
- Mask and RAW: MASK=0x000 with pending edges -> irq=0; write MASK=0x010 with edge_cap[4]=1 -> irq=1 one cycle later. Reading RAW tracks sync two clocks after a pin change, while DATA still holds the old level.
- Bus: reading MASK with write=1 and read=1 at the same time -> a write occurs and readData is unchanged. Writing DATA=0xFFFFFFFF -> DATA is unaffected.
